// File: rtl/sync_updown_counter_if.sv
// Control/status bundle for sync_updown_counter; the master drives controls, the slave (counter) drives status.
interface sync_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             Count_En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] Load_Val;
  logic             Clr_Flag;
  logic [WIDTH-1:0] Q;
  logic             Carry;
  logic             Borrow;
  logic             Zero;
  logic             Max;
  logic             Wrapped;

  modport master (
    output Count_En, Up, Load, Load_Val, Clr_Flag,
    input  Q, Carry, Borrow, Zero, Max, Wrapped
  );

  modport slave (
    input  Count_En, Up, Load, Load_Val, Clr_Flag,
    output Q, Carry, Borrow, Zero, Max, Wrapped
  );
endinterface

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-MODULUS up/down counter with clamped parallel load, Carry/Borrow pulses and sticky Wrapped.
// Optional build macro SATURATE_EN: steps stop at the limits instead of wrapping; Carry/Borrow then flag saturation hits.
module sync_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input logic                 CLK,
  input logic                 Reset,
  sync_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic             r_borrow;
  logic             r_wrapped;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_load_val;
  logic             w_carry_next;
  logic             w_borrow_next;
  logic             w_wrapped_next;

  // Out-of-range load values are clamped to the top of the count range.
  assign w_load_val = (bus.Load_Val > MAX_VAL) ? MAX_VAL : bus.Load_Val;

  always_comb begin
    w_q_next      = r_q;
    w_carry_next  = 1'b0;
    w_borrow_next = 1'b0;
    if (bus.Load) begin
      w_q_next = w_load_val;
    end else if (bus.Count_En) begin
      if (bus.Up) begin
        if (r_q == MAX_VAL) begin
          w_carry_next = 1'b1;
`ifdef SATURATE_EN
          w_q_next = r_q;
`else
          w_q_next = '0;
`endif
        end else begin
          w_q_next = r_q + 1'b1;
        end
      end else begin
        if (r_q == '0) begin
          w_borrow_next = 1'b1;
`ifdef SATURATE_EN
          w_q_next = r_q;
`else
          w_q_next = MAX_VAL;
`endif
        end else begin
          w_q_next = r_q - 1'b1;
        end
      end
    end

    // A wrap event on the same edge as Clr_Flag keeps the flag set.
    w_wrapped_next = r_wrapped;
    if (w_carry_next || w_borrow_next) begin
      w_wrapped_next = 1'b1;
    end else if (bus.Clr_Flag) begin
      w_wrapped_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_q       <= '0;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_carry   <= w_carry_next;
      r_borrow  <= w_borrow_next;
      r_wrapped <= w_wrapped_next;
    end
  end

  assign bus.Q       = r_q;
  assign bus.Carry   = r_carry;
  assign bus.Borrow  = r_borrow;
  assign bus.Wrapped = r_wrapped;
  assign bus.Zero    = (r_q == '0);
  assign bus.Max     = (r_q == MAX_VAL);

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed self-checking bench: a WIDTH=3/MODULUS=6 counter for the main sequences plus a default-parameter instance.
module tb_sync_updown_counter;

  logic CLK;
  logic Reset;
  int   n_total;
  int   n_bad;

  sync_updown_counter_if #(.WIDTH(3)) bus6 ();
  sync_updown_counter_if #(.WIDTH(3)) bus8 ();

  sync_updown_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus6.slave)
  );

  sync_updown_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus8.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk6(input string tag, input int q, input int c, input int b, input int w);
    check_eq({tag, ".Q"},       32'(bus6.Q),       32'(q));
    check_eq({tag, ".Carry"},   32'(bus6.Carry),   32'(c));
    check_eq({tag, ".Borrow"},  32'(bus6.Borrow),  32'(b));
    check_eq({tag, ".Wrapped"}, 32'(bus6.Wrapped), 32'(w));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_q [7] = '{1, 2, 3, 4, 5, 0, 1};
    int exp_c [7] = '{0, 0, 0, 0, 0, 1, 0};
    int exp_w [7] = '{0, 0, 0, 0, 0, 1, 1};
    int exp_m [7] = '{0, 0, 0, 0, 1, 0, 0};
    n_total = 0;
    n_bad   = 0;

    Reset = 1'b1;
    bus6.Count_En = 1'b0; bus6.Up = 1'b0; bus6.Load = 1'b0; bus6.Load_Val = '0; bus6.Clr_Flag = 1'b0;
    bus8.Count_En = 1'b0; bus8.Up = 1'b0; bus8.Load = 1'b0; bus8.Load_Val = '0; bus8.Clr_Flag = 1'b0;
    #2;
    chk6("reset", 0, 0, 0, 0);
    check_eq("reset.Zero", 32'(bus6.Zero), 32'd1);
    check_eq("reset.Max",  32'(bus6.Max),  32'd0);
    #5;
    Reset = 1'b0;

    // Test 1: count up through the wrap
    bus6.Count_En = 1'b1; bus6.Up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk6($sformatf("up%0d", i), exp_q[i], exp_c[i], 0, exp_w[i]);
      check_eq($sformatf("up%0d.Max", i), 32'(bus6.Max), 32'(exp_m[i]));
    end

    // Test 2: from Q=0 count down through the borrow
    bus6.Count_En = 1'b0; bus6.Load = 1'b1; bus6.Load_Val = 3'd0;
    tick();
    chk6("load0", 0, 0, 0, 1);
    check_eq("load0.Zero", 32'(bus6.Zero), 32'd1);
    bus6.Load = 1'b0; bus6.Count_En = 1'b1; bus6.Up = 1'b0;
    tick();
    chk6("dn0", 5, 0, 1, 1);
    tick();
    chk6("dn1", 4, 0, 0, 1);

    // Test 3: load clamp, load wins over count
    bus6.Load = 1'b1; bus6.Load_Val = 3'd7; bus6.Up = 1'b1;
    tick();
    chk6("ld7", 5, 0, 0, 1);
    bus6.Load_Val = 3'd6;
    tick();
    chk6("ld6", 5, 0, 0, 1);
    bus6.Load_Val = 3'd3;
    tick();
    chk6("ld3", 3, 0, 0, 1);

    // Hold with flag clear
    bus6.Load = 1'b0; bus6.Count_En = 1'b0; bus6.Clr_Flag = 1'b1;
    tick();
    chk6("clr", 3, 0, 0, 0);
    bus6.Clr_Flag = 1'b0;
    tick();
    chk6("hold", 3, 0, 0, 0);

    // Test 4: wrap and clear on the same edge, set wins
    bus6.Load = 1'b1; bus6.Load_Val = 3'd5;
    tick();
    chk6("ld5", 5, 0, 0, 0);
    bus6.Load = 1'b0; bus6.Count_En = 1'b1; bus6.Up = 1'b1; bus6.Clr_Flag = 1'b1;
    tick();
    chk6("wrapclr", 0, 1, 0, 1);
    bus6.Count_En = 1'b0;
    tick();
    chk6("clr2", 0, 0, 0, 0);
    bus6.Clr_Flag = 1'b0;

    // Direction reversal
    bus6.Load = 1'b1; bus6.Load_Val = 3'd4;
    tick();
    bus6.Load = 1'b0; bus6.Count_En = 1'b1; bus6.Up = 1'b1;
    tick();
    chk6("rev_up", 5, 0, 0, 0);
    bus6.Up = 1'b0;
    tick();
    chk6("rev_dn", 4, 0, 0, 0);

    // Test 5: async reset mid-cycle while Q=4 and Wrapped=1
    bus6.Count_En = 1'b0; bus6.Load = 1'b1; bus6.Load_Val = 3'd0;
    tick();
    bus6.Load = 1'b0; bus6.Count_En = 1'b1; bus6.Up = 1'b0;
    tick();
    chk6("pre_rst0", 5, 0, 1, 1);
    tick();
    chk6("pre_rst1", 4, 0, 0, 1);
    #2;
    Reset = 1'b1;
    #1;
    chk6("async_rst", 0, 0, 0, 0);
    check_eq("async_rst.Zero", 32'(bus6.Zero), 32'd1);
    bus6.Count_En = 1'b0;
    #3;
    Reset = 1'b0;

    // Default modulus: 7 up -> 0 with Carry
    bus8.Load = 1'b1; bus8.Load_Val = 3'd7;
    tick();
    check_eq("m8.ld7.Q",   32'(bus8.Q),   32'd7);
    check_eq("m8.ld7.Max", 32'(bus8.Max), 32'd1);
    bus8.Load = 1'b0; bus8.Count_En = 1'b1; bus8.Up = 1'b1;
    tick();
    check_eq("m8.wrap.Q",       32'(bus8.Q),       32'd0);
    check_eq("m8.wrap.Carry",   32'(bus8.Carry),   32'd1);
    check_eq("m8.wrap.Wrapped", 32'(bus8.Wrapped), 32'd1);
    check_eq("m6.idle.Q",       32'(bus6.Q),       32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
